lsb_mem_responder: RTL and testbench

- Memory-side responder for the load/store buffer's request interface. Accepts one load or store at a time and serialises it into byte accesses on the 8-bit unified RAM/IO port.
- For loads, returns the sign- or zero-extended result to the load/store buffer with a one-cycle done pulse.
- Sits between the load/store buffer and the top-level RAM/IO bus.

---
 rtl/lsb_mem_responder_if.sv | 45 ++++
 rtl/lsb_mem_responder.sv | 209 ++++++++++++++++++++
 tb/tb_lsb_mem_responder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsb_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsb_mem_responder_if
//  Description : Bundle of the load/store-buffer request/response signals
//                and the byte-wide RAM/IO bus seen by lsb_mem_responder.
//                slave  : the responder side (drives done/rdata and mem_*).
//                master : the environment side (requester, RAM, IO, control).
//                Signals: rdy, rollback, lsb_req_{valid,load,addr,data,precise},
//                lsb_done, lsb_rdata, mem_din, mem_dout, mem_a, mem_wr,
//                io_buffer_full.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsb_mem_responder_if;
    logic        rdy;
    logic        rollback;
    logic        lsb_req_valid;
    logic        lsb_req_load;
    logic [31:0] lsb_req_addr;
    logic [31:0] lsb_req_data;
    logic [2:0]  lsb_req_precise;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport slave (
        input  rdy, rollback,
        input  lsb_req_valid, lsb_req_load, lsb_req_addr, lsb_req_data, lsb_req_precise,
        output lsb_done, lsb_rdata,
        input  mem_din, io_buffer_full,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output rdy, rollback,
        output lsb_req_valid, lsb_req_load, lsb_req_addr, lsb_req_data, lsb_req_precise,
        input  lsb_done, lsb_rdata,
        output mem_din, io_buffer_full,
        input  mem_dout, mem_a, mem_wr
    );
endinterface
`default_nettype wire

// File: rtl/lsb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : lsb_mem_responder
//  Description : Memory-side responder for the load/store buffer. Takes one
//                load or store at a time and serialises it into byte accesses
//                on the 8-bit RAM/IO port; loads return a sign/zero-extended
//                result with a one-cycle lsb_done pulse.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset
//                bus  - lsb_mem_responder_if.slave (request/response + RAM/IO)
//  Parameters  : IO_SEL_HI - addr[17:16] value marking the IO region
//  Revision    : 1.0 - initial release
// ============================================================================
module lsb_mem_responder #(
    parameter logic [1:0] IO_SEL_HI = 2'b11
) (
    input  logic                clk,
    input  logic                rst,
    lsb_mem_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_COOL  = 2'd3
    } state_t;

    state_t      r_state,    w_state;
    logic [31:0] r_addr,     w_addr;
    logic [31:0] r_data,     w_data;
    logic        r_zext,     w_zext;
    logic [2:0]  r_n,        w_n;       // access size in bytes (1, 2 or 4)
    logic [2:0]  r_cnt,      w_cnt;     // bytes addressed/written so far
    logic [2:0]  r_rcnt,     w_rcnt;    // read edges taken in READ
    logic [31:0] r_buf,      w_buf;     // load byte slots, little-endian
    logic        r_done,     w_done;
    logic [31:0] r_rdata,    w_rdata;
    logic [31:0] r_mem_a,    w_mem_a;
    logic [7:0]  r_mem_dout, w_mem_dout;
    logic        r_wr_q,     w_wr_q;

    // The RAM keeps reading while rdy is low, so the byte that belongs to the
    // first frozen edge would be overwritten by the time the block resumes.
    // It is parked in r_hold and substituted on the first live edge.
    logic        r_stall;
    logic [7:0]  r_hold;

    logic [7:0]  w_din;
    logic [1:0]  w_slot;
    logic [2:0]  w_req_n;
    logic        w_req_io_stall;
    logic        w_wr_io_stall;

    function automatic logic [31:0] f_extend(input logic [31:0] raw,
                                             input logic [2:0]  n,
                                             input logic        zext);
        logic [31:0] res;
        case (n)
            3'd1:    res = zext ? {24'd0, raw[7:0]}  : {{24{raw[7]}},  raw[7:0]};
            3'd2:    res = zext ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    assign w_din          = r_stall ? r_hold : bus.mem_din;
    // The byte arriving on this edge was addressed one live edge earlier,
    // hence the slot trails the read-edge count by one.
    assign w_slot         = r_rcnt[1:0] - 2'd1;
    assign w_req_n        = (bus.lsb_req_precise[1:0] == 2'b00) ? 3'd1 :
                            (bus.lsb_req_precise[1:0] == 2'b01) ? 3'd2 : 3'd4;
    assign w_req_io_stall = bus.io_buffer_full && (bus.lsb_req_addr[17:16] == IO_SEL_HI);
    assign w_wr_io_stall  = bus.io_buffer_full && (r_addr[17:16] == IO_SEL_HI);

    always_comb begin
        w_state    = r_state;
        w_addr     = r_addr;
        w_data     = r_data;
        w_zext     = r_zext;
        w_n        = r_n;
        w_cnt      = r_cnt;
        w_rcnt     = r_rcnt;
        w_buf      = r_buf;
        w_done     = 1'b0;
        w_rdata    = r_rdata;
        w_mem_a    = r_mem_a;
        w_mem_dout = r_mem_dout;
        w_wr_q     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.lsb_req_valid && !bus.rollback) begin
                    w_addr = bus.lsb_req_addr;
                    w_data = bus.lsb_req_data;
                    w_zext = bus.lsb_req_precise[2];
                    w_n    = w_req_n;
                    w_rcnt = 3'd0;
                    if (bus.lsb_req_load) begin
                        w_mem_a = bus.lsb_req_addr;
                        w_cnt   = 3'd1;
                        w_state = S_READ;
                    end else if (!w_req_io_stall) begin
                        w_wr_q     = 1'b1;
                        w_mem_a    = bus.lsb_req_addr;
                        w_mem_dout = bus.lsb_req_data[7:0];
                        w_cnt      = 3'd1;
                        w_state    = S_WRITE;
                    end else begin
                        w_cnt   = 3'd0;
                        w_state = S_WRITE;
                    end
                end
            end

            S_READ: begin
                if (bus.rollback) begin
                    w_state = S_COOL;
                end else begin
                    if (r_rcnt != 3'd0) begin
                        w_buf[{w_slot, 3'b000} +: 8] = w_din;
                    end
                    if (r_cnt < r_n) begin
                        w_mem_a = r_addr + {29'd0, r_cnt};
                        w_cnt   = r_cnt + 3'd1;
                    end
                    w_rcnt = r_rcnt + 3'd1;
                    if (r_rcnt == r_n) begin
                        w_done  = 1'b1;
                        w_rdata = f_extend(w_buf, r_n, r_zext);
                        w_state = S_COOL;
                    end
                end
            end

            S_WRITE: begin
                // Rollback is deliberately not looked at: a store that has
                // reached this block is committed.
                if (r_cnt == r_n) begin
                    w_done  = 1'b1;
                    w_state = S_COOL;
                end else if (!w_wr_io_stall) begin
                    w_wr_q     = 1'b1;
                    w_mem_a    = r_addr + {29'd0, r_cnt};
                    w_mem_dout = r_data[{r_cnt[1:0], 3'b000} +: 8];
                    w_cnt      = r_cnt + 3'd1;
                end
            end

            // One dead cycle: the requester drops its level one cycle after
            // it sees done, so a still-high valid here is stale.
            S_COOL: begin
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= 32'd0;
            r_data     <= 32'd0;
            r_zext     <= 1'b0;
            r_n        <= 3'd0;
            r_cnt      <= 3'd0;
            r_rcnt     <= 3'd0;
            r_buf      <= 32'd0;
            r_done     <= 1'b0;
            r_rdata    <= 32'd0;
            r_mem_a    <= 32'd0;
            r_mem_dout <= 8'd0;
            r_wr_q     <= 1'b0;
            r_stall    <= 1'b0;
            r_hold     <= 8'd0;
        end else begin
            r_stall <= ~bus.rdy;
            if (!bus.rdy && !r_stall) begin
                r_hold <= bus.mem_din;
            end
            if (bus.rdy) begin
                r_state    <= w_state;
                r_addr     <= w_addr;
                r_data     <= w_data;
                r_zext     <= w_zext;
                r_n        <= w_n;
                r_cnt      <= w_cnt;
                r_rcnt     <= w_rcnt;
                r_buf      <= w_buf;
                r_done     <= w_done;
                r_rdata    <= w_rdata;
                r_mem_a    <= w_mem_a;
                r_mem_dout <= w_mem_dout;
                r_wr_q     <= w_wr_q;
            end
        end
    end

    assign bus.lsb_done  = r_done;
    assign bus.lsb_rdata = r_rdata;
    assign bus.mem_a     = r_mem_a;
    assign bus.mem_dout  = r_mem_dout;
    assign bus.mem_wr    = r_wr_q & bus.rdy;

endmodule
`default_nettype wire

// File: tb/tb_lsb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsb_mem_responder
//  Description : Scoreboard testbench for lsb_mem_responder. A driver issues
//                directed and random loads/stores, pushing the expected
//                completion (result and cycle) and expected RAM writes; a
//                monitor pops and compares whenever the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsb_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsb_mem_responder_if bus ();

    lsb_mem_responder #(.IO_SEL_HI(2'b11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    exp_t        exp_q[$];
    wr_t         exp_wr[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic        rst_q  = 1'b0;
    logic        end_req  = 1'b0;
    logic        end_done = 1'b0;
    logic [31:0] last_rdata;

    // RAM: byte array aliased on addr[11:0]; registered read, free running.
    logic [7:0]  ram     [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic        tb_we;
    logic [11:0] tb_wa;
    logic [7:0]  tb_wd;

    always @(posedge clk) begin
        if (tb_we)            ram[tb_wa] <= tb_wd;
        else if (bus.mem_wr)  ram[bus.mem_a[11:0]] <= bus.mem_dout;
        bus.mem_din <= ram[bus.mem_a[11:0]];
    end

    always @(posedge clk) begin
        cyc   = cyc + 1;
        rst_q = rst;
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] pr);
        case (pr[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] pr);
        int          n;
        logic [31:0] raw;
        logic [31:0] ak;
        n   = nbytes(pr);
        raw = 32'd0;
        for (int k = 0; k < n; k++) begin
            ak  = a + 32'(k);
            raw = raw | (32'(ref_mem[ak[11:0]]) << (8 * k));
        end
        if (n == 1) return pr[2] ? 32'(int'(raw[7:0]))  : 32'(int'($signed(raw[7:0])));
        if (n == 2) return pr[2] ? 32'(int'(raw[15:0])) : 32'(int'($signed(raw[15:0])));
        return raw;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        if (rst_q) begin
            checks++;
            if (bus.lsb_done !== 1'b0 || bus.lsb_rdata !== 32'd0 || bus.mem_a !== 32'd0 ||
                bus.mem_dout !== 8'd0 || bus.mem_wr !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: done=%b rdata=%h mem_a=%h dout=%h wr=%b, required all zero",
                         bus.lsb_done, bus.lsb_rdata, bus.mem_a, bus.mem_dout, bus.mem_wr);
            end
        end else begin
            if (bus.lsb_done && bus.rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: done at cycle %0d rdata=%h, none required", cyc, bus.lsb_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.lsb_rdata !== e.rdata || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL done_resp: rdata=%h cycle=%0d, required rdata=%h cycle=%0d",
                                 bus.lsb_rdata, cyc, e.rdata, e.cyc);
                    end
                end
            end
            if (bus.mem_wr) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: a=%h d=%h, none required", bus.mem_a, bus.mem_dout);
                end else begin
                    w = exp_wr.pop_front();
                    if (bus.mem_a !== w.a || bus.mem_dout !== w.d) begin
                        errors++;
                        $display("FAIL write: a=%h d=%h, required a=%h d=%h", bus.mem_a, bus.mem_dout, w.a, w.d);
                    end
                end
            end
        end
        if (end_req && !end_done) begin
            checks++;
            if (exp_q.size() != 0 || exp_wr.size() != 0) begin
                errors++;
                $display("FAIL leftover: %0d completions %0d writes outstanding, required 0 0",
                         exp_q.size(), exp_wr.size());
            end
            end_done = 1'b1;
        end
    end

    // ---------------- driver ----------------
    task automatic poke(input logic [11:0] a, input logic [7:0] v);
        @(posedge clk); #1;
        tb_we = 1'b1; tb_wa = a; tb_wd = v; ref_mem[a] = v;
    endtask

    task automatic idle_inputs();
        bus.lsb_req_valid  = 1'b0;
        bus.rollback       = 1'b0;
        bus.io_buffer_full = 1'b0;
        bus.rdy            = 1'b1;
    endtask

    // io_cyc  : io_buffer_full held for the first io_cyc edges from accept
    // frz_*   : rdy low for frz_len edges starting frz_at edges after accept
    // rb_at   : rollback pulse on the edge rb_at after accept
    // rb_idle : rollback on the presentation edge, delaying accept by one
    task automatic run_req(input bit ld, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] pr, input int io_cyc, input int frz_at,
                           input int frz_len, input int rb_at, input bit rb_idle);
        int          n, lat, off, s, p, done_t;
        bit          aborted;
        exp_t        e;
        logic [31:0] ak;
        n       = nbytes(pr);
        off     = rb_idle ? 1 : 0;
        s       = (!ld && a[17:16] == 2'b11) ? io_cyc : 0;
        lat     = (ld ? n + 1 : n + s) + frz_len;
        aborted = ld && (rb_at > 0);

        @(posedge clk); #1;
        p = cyc;
        if (!aborted) begin
            if (ld) last_rdata = model_load(a, pr);
            e.rdata = last_rdata;
            e.cyc   = p + 1 + off + lat;
            exp_q.push_back(e);
        end
        if (!ld) begin
            for (int k = 0; k < n; k++) begin
                ak = a + 32'(k);
                exp_wr.push_back({ak, d[8*k +: 8]});
                ref_mem[ak[11:0]] = d[8*k +: 8];
            end
        end
        bus.lsb_req_valid   = 1'b1;
        bus.lsb_req_load    = ld;
        bus.lsb_req_addr    = a;
        bus.lsb_req_data    = d;
        bus.lsb_req_precise = pr;
        bus.io_buffer_full  = (io_cyc > 0);
        bus.rollback        = rb_idle;

        done_t = -1;
        for (int t = 1; t <= 60; t++) begin
            @(posedge clk); #1;
            if (done_t >= 0 && t == done_t + 1) break;
            if (bus.lsb_done && bus.rdy && done_t < 0) done_t = t;
            if (rb_idle && t == 1) bus.rollback = 1'b0;
            if (io_cyc > 0 && t == off + io_cyc) bus.io_buffer_full = 1'b0;
            if (frz_len > 0 && t == off + frz_at) bus.rdy = 1'b0;
            if (frz_len > 0 && t == off + frz_at + frz_len) bus.rdy = 1'b1;
            if (rb_at > 0 && t == off + rb_at) begin
                bus.rollback = 1'b1;
                if (ld) bus.lsb_req_valid = 1'b0;
            end
            if (rb_at > 0 && t == off + rb_at + 1) bus.rollback = 1'b0;
            if (aborted && t == off + n + 6) break;
        end
        idle_inputs();
    endtask

    initial begin
        rst   = 1'b1;
        tb_we = 1'b0; tb_wa = 12'd0; tb_wd = 8'd0;
        last_rdata = 32'd0;
        bus.lsb_req_load = 1'b0; bus.lsb_req_addr = 32'd0;
        bus.lsb_req_data = 32'd0; bus.lsb_req_precise = 3'd0;
        idle_inputs();

        for (int i = 0; i < 4096; i++) poke(12'(i), 8'($urandom));
        poke(12'h100, 8'h80);
        poke(12'h200, 8'h11); poke(12'h201, 8'h22);
        poke(12'h202, 8'h33); poke(12'h203, 8'h44);
        @(posedge clk); #1;
        tb_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        run_req(1, 32'h100,   32'h0,        3'b000, 0, 0, 0, 0, 0);   // LB  -> FFFFFF80
        run_req(1, 32'h100,   32'h0,        3'b100, 0, 0, 0, 0, 0);   // LBU -> 00000080
        run_req(1, 32'h200,   32'h0,        3'b010, 0, 0, 0, 0, 0);   // LW  -> 44332211
        run_req(0, 32'h300,   32'hDEADBEEF, 3'b001, 0, 0, 0, 0, 0);   // SH
        run_req(0, 32'h30000, 32'h0000005A, 3'b000, 3, 0, 0, 0, 0);   // SB, IO stall 3
        run_req(1, 32'h200,   32'h0,        3'b010, 0, 0, 0, 2, 0);   // LW rolled back
        run_req(1, 32'h200,   32'h0,        3'b010, 0, 0, 0, 0, 0);   // accepted after COOL
        run_req(0, 32'h400,   32'h01234567, 3'b010, 0, 0, 0, 2, 0);   // SW, rollback ignored
        run_req(1, 32'h400,   32'h0,        3'b010, 0, 2, 2, 0, 0);   // LW, rdy low 2
        run_req(1, 32'h300,   32'h0,        3'b101, 0, 0, 0, 0, 1);   // LHU, rollback in IDLE
        run_req(1, 32'h300,   32'h0,        3'b001, 0, 0, 0, 0, 0);   // LH
        run_req(1, 32'hFFFFFFFE, 32'h0,     3'b011, 0, 0, 0, 0, 0);   // word, address wrap

        for (int r = 0; r < 200; r++) begin
            bit          ld, ri;
            logic [31:0] a, d;
            logic [2:0]  pr;
            int          io_c, fa, fl, rb, n;
            ld = 1'($urandom_range(0, 1));
            a  = $urandom;
            d  = $urandom;
            pr = 3'($urandom);
            n  = nbytes(pr);
            io_c = 0; fa = 0; fl = 0; rb = 0; ri = 1'b0;
            case ($urandom_range(0, 4))
                0:       if (!ld) io_c = $urandom_range(1, 3);
                1:       begin fa = $urandom_range(1, n); fl = $urandom_range(1, 3); end
                2:       rb = $urandom_range(1, n);
                3:       ri = 1'b1;
                default: ;
            endcase
            run_req(ld, a, d, pr, io_c, fa, fl, rb, ri);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Reset in the middle of a word load: access abandoned, no done.
        @(posedge clk); #1;
        bus.lsb_req_valid = 1'b1; bus.lsb_req_load = 1'b1;
        bus.lsb_req_addr = 32'h200; bus.lsb_req_precise = 3'b010;
        repeat (2) @(posedge clk); #1;
        rst = 1'b1; bus.lsb_req_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        last_rdata = 32'd0;
        run_req(0, 32'h500, 32'hCAFEF00D, 3'b010, 0, 0, 0, 0, 0);     // rdata stays 0
        run_req(1, 32'h500, 32'h0,        3'b000, 0, 0, 0, 0, 0);

        repeat (4) @(posedge clk);
        end_req = 1'b1;
        for (int i = 0; i < 10 && !end_done; i++) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
